mem_xfer_sequencer: RTL and testbench
=====================================

# mem_xfer_sequencer

Controller for the two-memory transfer datapath. On a `start` pulse it fills memory A with `DEPTH` words from the external producer, reads A back one word at a time, and copies only the words below a threshold into memory B at consecutive addresses. Each run ends with a one-cycle `done` pulse. The block drives the addresses and write enables of both RAMs; the RAMs, the data muxes and the producer sit outside it.

## Interface
Parameters:
- `DEPTH`, default 8: words per transfer; must be ≥2.
- `AW`, default 3: address width; must equal clog2(`DEPTH`).
- `DW`, default 8: data width of memory A.

Ports:
- `clock`  in  1: clock, rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a transfer; sampled only in IDLE.
- `threshold`  in  DW: filter limit; captured on accepted `start`.
- `rdata_a`  in  DW: memory A read data; synchronous RAM, 1-cycle latency.
- `addr_a`  out  AW: memory A address.
- `wea`  out  1: memory A write enable.
- `addr_b`  out  AW: memory B address.
- `web`  out  1: memory B write enable.
- `busy`  out  1: high while state ≠ IDLE.
- `done`  out  1: one-cycle pulse at end of transfer.
- `count_b`  out  AW+1: number of words written to B in the last or current run.

## Operation
- State register: IDLE, FILL, READ, EVAL, DONE.
- `wea`, `web`, `busy` and `done` are decoded from the state register. `addr_a`, `addr_b` and `count_b` are registers.
- **IDLE**
  - All enables are 0.
  - `start`=1: go to FILL; `addr_a`←0, `addr_b`←0, `count_b`←0; latch `threshold` into `thr_q`.
- **FILL**
  - `wea`=1.
  - Each cycle: if `addr_a`=`DEPTH`-1, `addr_a`←0 and go to READ; otherwise `addr_a`←`addr_a`+1.
- **READ**
  - `addr_a` held, enables 0; go to EVAL.
- **EVAL**
  - `rdata_a` is valid for the current `addr_a`.
  - Keep when `rdata_a` < `thr_q` (unsigned, strict). On keep: `web`=1 this cycle at the current `addr_b`; on the edge, `addr_b`←`addr_b`+1 (wraps modulo 2^AW) and `count_b`←`count_b`+1.
  - If `addr_a`=`DEPTH`-1, go to DONE; otherwise `addr_a`←`addr_a`+1 and go to READ.
- **DONE**
  - `done`=1; go to IDLE.
  - `count_b` and `addr_b` hold until the next accepted `start`.
- `start` in any state other than IDLE is ignored; it is not queued.
- Changes on `threshold` after the `start` edge have no effect on the current run.
- `Reset` (any state, including mid-run): state←IDLE; `addr_a`, `addr_b`, `count_b` and `thr_q` ←0. All outputs read 0 after that edge. Reset has priority over `start` in the same cycle.

## Timing
- Reset values: every output is 0.
- `start` is sampled at edge E0.
- FILL occupies the cycles following E0 through E`DEPTH`.
- READ/EVAL pairs take 2·`DEPTH` cycles.
- `done` is high in the cycle after edge E(3·`DEPTH`); IDLE follows one edge later. For `DEPTH`=8, `done` is high in the cycle following E24.
- Run length is independent of how many words are kept.
- Earliest restart: `start` sampled on the first IDLE edge after DONE.
- All keep: `count_b`=`DEPTH` and `addr_b` wraps to 0 at the end of the run.

## Configuration
- `MEM_XFER_ABORT_EN` defined:
  - Adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - `abort`=1 in FILL, READ or EVAL: next state DONE, and `aborted`←1 on the same edge.
  - An EVAL cycle with `abort`=1 still performs its `web` write if the word is kept.
  - `aborted` clears on the next accepted `start` or on `Reset`.
  - `abort` in IDLE or DONE is ignored.
- Undefined: neither port exists, and every run completes in the fixed 3·`DEPTH`+1 cycles.

## Test plan
- Filtered run:
  - Setup: `DEPTH`=8, `threshold`=0x10; A loaded 05,20,0F,10,00,FF,01,11.
  - `web` pulses at `addr_a`=0,2,4,6 with `addr_b`=0,1,2,3; 0x10 is not kept.
  - `count_b`=4; `done` in the cycle after E24.
- All kept: `threshold`=0xFF with all data 0 → 8 `web` pulses, `addr_b` 0..7 then wraps to 0, `count_b`=8.
- None kept: `threshold`=0 → `web` never asserts, `count_b`=0, `done` timing identical to the filtered run.
- Ignored inputs: `start` re-pulsed and `threshold` changed to 0 in the middle of a busy run → no restart, original filter result (`count_b`=4), `done` at the same cycle.
- Reset mid-run: `Reset` in the 3rd FILL cycle → all outputs 0 after that edge; the next `start` yields a complete, correct run.
- Abort (macro on): `abort` during EVAL of `addr_a`=3 → DONE next cycle, `done` and `aborted`=1, `count_b` reflects only words 0–3.

Source files
------------

// File: rtl/mem_xfer_sequencer_if.sv
// Bus bundle between mem_xfer_sequencer and its RAMs/producer environment.
// The abort/aborted pair exists only when MEM_XFER_ABORT_EN is defined.
interface mem_xfer_sequencer_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  // start is a level sampled only while the sequencer is idle; there is no
  // ready return: a start seen while busy is dropped, never queued.
  logic          start;
  logic [DW-1:0] threshold;
  logic [DW-1:0] rdata_a;
  logic [AW-1:0] addr_a;
  logic          wea;
  logic [AW-1:0] addr_b;
  logic          web;
  logic          busy;
  logic          done;
  logic [AW:0]   count_b;
`ifdef MEM_XFER_ABORT_EN
  logic          abort;
  logic          aborted;
`endif

  modport master (
`ifdef MEM_XFER_ABORT_EN
    input  abort,
    output aborted,
`endif
    input  start, threshold, rdata_a,
    output addr_a, wea, addr_b, web, busy, done, count_b
  );

  modport slave (
`ifdef MEM_XFER_ABORT_EN
    output abort,
    input  aborted,
`endif
    output start, threshold, rdata_a,
    input  addr_a, wea, addr_b, web, busy, done, count_b
  );
endinterface

// File: rtl/mem_xfer_sequencer.sv
// Fill memory A from the producer, then copy words below a threshold into B.
// Optional abort support is compiled in with MEM_XFER_ABORT_EN.
module mem_xfer_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic                  clock,
  input  logic                  Reset,
  mem_xfer_sequencer_if.master  bus,
  output logic [2:0]            state_dbg
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_READ = 3'd2,
    S_EVAL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_a_q, addr_b_q;
  logic [AW:0]   count_b_q;
  logic [DW-1:0] thr_q;
  logic          keep;
  logic          abort_req;

`ifdef MEM_XFER_ABORT_EN
  logic aborted_q;
  assign abort_req   = bus.abort && (state_q inside {S_FILL, S_READ, S_EVAL});
  assign bus.aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  // rdata_a reflects the address presented during the preceding READ cycle.
  assign keep = (state_q == S_EVAL) && (bus.rdata_a < thr_q);

  always_ff @(posedge clock) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_FILL;
      S_FILL: if (addr_a_q == LAST) state_d = S_READ;
      S_READ: state_d = S_EVAL;
      S_EVAL: state_d = (addr_a_q == LAST) ? S_DONE : S_READ;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_req) state_d = S_DONE;
  end

  always_comb begin
    bus.wea  = (state_q == S_FILL);
    bus.web  = keep;
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      count_b_q <= '0;
      thr_q     <= '0;
`ifdef MEM_XFER_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          addr_a_q  <= '0;
          addr_b_q  <= '0;
          count_b_q <= '0;
          thr_q     <= bus.threshold;
`ifdef MEM_XFER_ABORT_EN
          aborted_q <= 1'b0;
`endif
        end
        S_FILL: addr_a_q <= (addr_a_q == LAST) ? '0 : addr_a_q + 1'b1;
        S_EVAL: begin
          // addr_b wraps naturally, so an all-keep run leaves it at 0.
          if (keep) begin
            addr_b_q  <= addr_b_q + 1'b1;
            count_b_q <= count_b_q + 1'b1;
          end
          if (addr_a_q != LAST) addr_a_q <= addr_a_q + 1'b1;
        end
        default: ;
      endcase
`ifdef MEM_XFER_ABORT_EN
      if (abort_req) aborted_q <= 1'b1;
`endif
    end
  end

  assign bus.addr_a  = addr_a_q;
  assign bus.addr_b  = addr_b_q;
  assign bus.count_b = count_b_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mem_xfer_sequencer.sv
// Directed bench for mem_xfer_sequencer: vector table of filter runs plus
// hand-written reset-mid-run and (when MEM_XFER_ABORT_EN) abort sequences.
module tb_mem_xfer_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DW    = 8;

  logic       clock = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] state_dbg;

  mem_xfer_sequencer_if #(.AW(AW), .DW(DW)) bus();

  mem_xfer_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock     (clock),
    .Reset     (Reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  // producer + memory A model: synchronous RAM, read-first, 1-cycle latency
  logic [7:0]  mem_a [DEPTH];
  logic [63:0] fill_data;
  always @(posedge clock) begin
    if (bus.wea) mem_a[bus.addr_a] <= fill_data[{bus.addr_a, 3'b000} +: 8];
    bus.rdata_a <= mem_a[bus.addr_a];
  end

  typedef struct {
    logic [7:0]  thr;
    logic [63:0] data;      // word i in bits [8i+7:8i]
    logic [7:0]  web_mask;  // bit i set when word i is kept
    int          exp_count;
    int          exp_addr_b;
    bit          disturb;   // re-pulse start and zero threshold mid-run
  } vec_t;

  // scoreboard: expected {addr_a, addr_b} of each web pulse
  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    int b;
    logic [5:0] e;
    fill_data = v.data;
    exp_q.delete();
    b = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v.web_mask[i]) begin
        exp_q.push_back({3'(i), 3'(b)});
        b++;
      end
    end
    bus.threshold = v.thr;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    chk($sformatf("v%0d_busy_start", idx), bus.busy, 1);
    chk($sformatf("v%0d_wea_start", idx), bus.wea, 1);
    k = 0;
    while (k < 40 && !bus.done) begin
      if (v.disturb && k == 10) begin
        bus.start     = 1'b1;
        bus.threshold = 8'h00;
      end
      if (v.disturb && k == 11) bus.start = 1'b0;
      if (bus.web) begin
        if (exp_q.size() == 0) chk($sformatf("v%0d_web_extra", idx), 1, 0);
        else begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d_web_addr_ab", idx), {bus.addr_a, bus.addr_b}, e);
        end
      end
      step();
      k++;
    end
    chk($sformatf("v%0d_done_cycle", idx), k, 24);
    chk($sformatf("v%0d_count_b", idx), bus.count_b, v.exp_count);
    chk($sformatf("v%0d_addr_b", idx), bus.addr_b, v.exp_addr_b);
    chk($sformatf("v%0d_web_missing", idx), exp_q.size(), 0);
    step();
    chk($sformatf("v%0d_idle_busy", idx), bus.busy, 0);
    chk($sformatf("v%0d_idle_done", idx), bus.done, 0);
    chk($sformatf("v%0d_hold_count_b", idx), bus.count_b, v.exp_count);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr_a"},  bus.addr_a, 0);
    chk({tag, "_addr_b"},  bus.addr_b, 0);
    chk({tag, "_count_b"}, bus.count_b, 0);
    chk({tag, "_wea"},     bus.wea, 0);
    chk({tag, "_web"},     bus.web, 0);
    chk({tag, "_busy"},    bus.busy, 0);
    chk({tag, "_done"},    bus.done, 0);
    chk({tag, "_state"},   state_dbg, 0);
  endtask

  vec_t vecs [5];

  initial begin
    vecs[0] = '{thr: 8'h10, data: 64'h11_01_FF_00_10_0F_20_05, web_mask: 8'h55,
                exp_count: 4, exp_addr_b: 4, disturb: 1'b0};
    vecs[1] = '{thr: 8'hFF, data: 64'h00_00_00_00_00_00_00_00, web_mask: 8'hFF,
                exp_count: 8, exp_addr_b: 0, disturb: 1'b0};
    vecs[2] = '{thr: 8'h00, data: 64'h11_01_FF_00_10_0F_20_05, web_mask: 8'h00,
                exp_count: 0, exp_addr_b: 0, disturb: 1'b0};
    vecs[3] = '{thr: 8'h10, data: 64'h11_01_FF_00_10_0F_20_05, web_mask: 8'h55,
                exp_count: 4, exp_addr_b: 4, disturb: 1'b1};
    vecs[4] = '{thr: 8'h80, data: 64'h01_80_7F_FE_00_81_80_7F, web_mask: 8'hA9,
                exp_count: 4, exp_addr_b: 4, disturb: 1'b0};

    bus.start     = 1'b0;
    bus.threshold = 8'h00;
    fill_data     = 64'h0;
`ifdef MEM_XFER_ABORT_EN
    bus.abort = 1'b0;
`endif

    Reset = 1'b1;
    step();
    step();
    chk_all_zero("reset");
`ifdef MEM_XFER_ABORT_EN
    chk("reset_aborted", bus.aborted, 0);
`endif
    Reset = 1'b0;
    step();

    // Reset during the third FILL cycle
    fill_data     = vecs[0].data;
    bus.threshold = 8'h10;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("midrst_addr_a_pre", bus.addr_a, 2);
    Reset = 1'b1;
    step();
    chk_all_zero("midrst");
    Reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

`ifdef MEM_XFER_ABORT_EN
    // abort during EVAL of word 3: only words 0..3 count (05,0F kept)
    begin
      int k;
      fill_data     = vecs[0].data;
      bus.threshold = 8'h10;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      for (k = 0; k < 15; k++) step();
      chk("abort_state_eval", state_dbg, 3);
      chk("abort_addr_a", bus.addr_a, 3);
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
      chk("abort_done", bus.done, 1);
      chk("abort_aborted", bus.aborted, 1);
      chk("abort_count_b", bus.count_b, 2);
      step();
      chk("abort_idle_busy", bus.busy, 0);
      chk("abort_sticky", bus.aborted, 1);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("abort_clear_on_start", bus.aborted, 0);
      k = 0;
      while (k < 40 && !bus.done) begin
        step();
        k++;
      end
      chk("abort_rerun_done_cycle", k, 24);
      chk("abort_rerun_count_b", bus.count_b, 4);
      step();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
